// File: rtl/bitstream_pkg.sv
// Shared types and default widths for the bitstreamer frame scheduler.
// Descriptor fields are packed {data, phase, repeat} in the FIFO word.
package bitstream_pkg;

    localparam int DEF_DATALEN = 64;
    localparam int DEF_CNTLEN  = 8;
    localparam int DEF_GAPLEN  = 16;
    localparam int DEF_TOLEN   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int REPLEN      = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_RUN  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5,
        ERROR     = 3'd6
    } sched_state_t;

    function automatic int desc_width(input int datalen, input int cntlen);
        return datalen + cntlen + REPLEN;
    endfunction

endpackage

// File: rtl/desc_fifo.sv
// Small synchronous descriptor FIFO with show-ahead head word and fill level.
// Pointers carry one extra wrap bit so full/empty need no separate flag.
module desc_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitstream_sched.sv
// Frame scheduler for the bitstreamer core: queues descriptors, issues start
// pulses, tracks sysrun, inserts inter-frame gaps and recovers from stalls.
module bitstream_sched
    import bitstream_pkg::*;
#(
    parameter int DATALEN = DEF_DATALEN,
    parameter int CNTLEN  = DEF_CNTLEN,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int GAPLEN  = DEF_GAPLEN,
    parameter int TOLEN   = DEF_TOLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [DATALEN-1:0]     desc_data,
    input  logic [CNTLEN-1:0]      desc_phase,
    input  logic [7:0]             desc_repeat,
    input  logic [GAPLEN-1:0]      gap_cycles,
    input  logic [TOLEN-1:0]       timeout_cycles,
    input  logic                   clr_err,
    output logic [DATALEN-1:0]     bs_datain,
    output logic [CNTLEN-1:0]      bs_phase_delay,
    output logic                   bs_start,
    output logic                   bs_rst,
    input  logic                   bs_sysrun,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int DW = desc_width(DATALEN, CNTLEN);

    sched_state_t state_reg, state_next;

    logic [DW-1:0]      fifo_wr_data;
    logic [DW-1:0]      fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    logic [DATALEN-1:0] head_data;
    logic [CNTLEN-1:0]  head_phase;
    logic [REPLEN-1:0]  head_repeat;

    logic [DATALEN-1:0] bs_datain_reg;
    logic [CNTLEN-1:0]  bs_phase_reg;
    logic               bs_rst_reg;
    logic               err_timeout_reg;
    logic               frame_done_reg;
    logic [REPLEN-1:0]  rep_cnt_reg;
    logic [TOLEN-1:0]   to_cnt_reg;
    logic [GAPLEN-1:0]  gap_cnt_reg;
    logic [TOLEN:0]     to_elapsed;
    logic               can_load;

    assign fifo_wr_data = {desc_data, desc_phase, desc_repeat};
    assign fifo_push    = desc_valid && !fifo_full;
    assign fifo_pop     = (state_reg == LOAD);
    assign desc_ready   = !fifo_full;

    assign head_data   = fifo_rd_data[DW-1 -: DATALEN];
    assign head_phase  = fifo_rd_data[REPLEN +: CNTLEN];
    assign head_repeat = fifo_rd_data[REPLEN-1:0];

    desc_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Elapsed WAIT_RUN cycles including the current one, so a zero timeout
    // trips on the very first cycle without sysrun.
    assign to_elapsed = {1'b0, to_cnt_reg} + (TOLEN+1)'(1);
    assign can_load   = enable && !fifo_empty;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (can_load) begin
                    state_next = LOAD;
                end
            end
            LOAD:  state_next = START;
            START: state_next = WAIT_RUN;
            WAIT_RUN: begin
                if (bs_sysrun) begin
                    state_next = WAIT_DONE;
                end else if (to_elapsed >= {1'b0, timeout_cycles}) begin
                    state_next = ERROR;
                end
            end
            WAIT_DONE: begin
                if (!bs_sysrun) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg >= gap_cycles) begin
                    if (rep_cnt_reg != '0) begin
                        state_next = START;
                    end else if (can_load) begin
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            ERROR: begin
                if (clr_err) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Core-facing data is captured on entry to LOAD so it leads bs_start
    // by a full cycle and stays put through every repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_datain_reg <= '0;
            bs_phase_reg  <= '0;
            rep_cnt_reg   <= '0;
        end else begin
            if (state_next == LOAD) begin
                bs_datain_reg <= head_data;
                bs_phase_reg  <= head_phase;
                rep_cnt_reg   <= head_repeat;
            end else if (state_reg == GAP && state_next == START) begin
                rep_cnt_reg <= rep_cnt_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg  <= '0;
            gap_cnt_reg <= '0;
        end else begin
            if (state_reg == START) begin
                to_cnt_reg <= '0;
            end else if (state_reg == WAIT_RUN) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            if (state_reg == WAIT_DONE) begin
                gap_cnt_reg <= '0;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
        end
    end

    // bs_rst resets high and falls on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_rst_reg      <= 1'b1;
            err_timeout_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            bs_rst_reg      <= (state_next == ERROR);
            err_timeout_reg <= (state_next == ERROR);
            frame_done_reg  <= (state_reg == WAIT_DONE) && !bs_sysrun;
        end
    end

    assign bs_datain      = bs_datain_reg;
    assign bs_phase_delay = bs_phase_reg;
    assign bs_start       = (state_reg == START);
    assign bs_rst         = bs_rst_reg;
    assign err_timeout    = err_timeout_reg;
    assign frame_done     = frame_done_reg;
    assign busy           = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bitstream_sched.sv
// Directed bench for bitstream_sched with a sysrun stub and a frame scoreboard.
module tb_bitstream_sched;

    localparam int DATALEN = 64;
    localparam int CNTLEN  = 8;
    localparam int DEPTH   = 4;
    localparam int GAPLEN  = 16;
    localparam int TOLEN   = 16;
    localparam int RUN_LEN = 6;

    typedef struct {
        logic [DATALEN-1:0] d;
        logic [CNTLEN-1:0]  p;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  enable = 1'b0;
    logic                  desc_valid = 1'b0;
    logic                  desc_ready;
    logic [DATALEN-1:0]    desc_data = '0;
    logic [CNTLEN-1:0]     desc_phase = '0;
    logic [7:0]            desc_repeat = '0;
    logic [GAPLEN-1:0]     gap_cycles = '0;
    logic [TOLEN-1:0]      timeout_cycles = 16'd50;
    logic                  clr_err = 1'b0;
    logic [DATALEN-1:0]    bs_datain;
    logic [CNTLEN-1:0]     bs_phase_delay;
    logic                  bs_start;
    logic                  bs_rst;
    logic                  bs_sysrun;
    logic                  busy;
    logic                  frame_done;
    logic                  err_timeout;
    logic [$clog2(DEPTH):0] fifo_level;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   n_fd = 0;
    int   start_q[$];
    int   fd_q[$];
    exp_t sb_q[$];
    logic stub_hold = 1'b0;
    int   stub_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitstream_sched #(
        .DATALEN (DATALEN),
        .CNTLEN  (CNTLEN),
        .DEPTH   (DEPTH),
        .GAPLEN  (GAPLEN),
        .TOLEN   (TOLEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_data      (desc_data),
        .desc_phase     (desc_phase),
        .desc_repeat    (desc_repeat),
        .gap_cycles     (gap_cycles),
        .timeout_cycles (timeout_cycles),
        .clr_err        (clr_err),
        .bs_datain      (bs_datain),
        .bs_phase_delay (bs_phase_delay),
        .bs_start       (bs_start),
        .bs_rst         (bs_rst),
        .bs_sysrun      (bs_sysrun),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_timeout    (err_timeout),
        .fifo_level     (fifo_level)
    );

    // Core stand-in: sysrun rises two cycles after start and lasts RUN_LEN cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 0;
        end else if (stub_cnt == 0) begin
            if (bs_start && !stub_hold) stub_cnt <= 1;
        end else if (stub_cnt == RUN_LEN + 1) begin
            stub_cnt <= 0;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign bs_sysrun = (stub_cnt >= 2);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) begin
                n_fd++;
                fd_q.push_back(cyc);
            end
            if (bs_start) begin
                exp_t e;
                n_start++;
                start_q.push_back(cyc);
                check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("bs_datain", bs_datain, e.d);
                    check("bs_phase_delay", 64'(bs_phase_delay), 64'(e.p));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_start = 0;
        n_fd = 0;
        start_q.delete();
        fd_q.delete();
    endtask

    task automatic push_desc(input logic [63:0] d, input logic [7:0] p, input logic [7:0] r);
        logic acc;
        exp_t e;
        acc = desc_ready;
        desc_valid = 1'b1;
        desc_data = d;
        desc_phase = p;
        desc_repeat = r;
        tick();
        desc_valid = 1'b0;
        if (acc) begin
            e.d = d;
            e.p = p;
            for (int i = 0; i <= int'(r); i++) sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_bs_rst", 64'(bs_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(desc_ready), 64'd1);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_datain", bs_datain, 64'd0);
        check("rst_start", 64'(bs_start), 64'd0);
        check("rst_fd", 64'(frame_done), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        rst_n = 1'b1;
        #2 check("rst_hold_bs_rst", 64'(bs_rst), 64'd1);
        tick();
        check("rst_release_bs_rst", 64'(bs_rst), 64'd0);

        // Single frame with latency checks
        gap_cycles = 16'd5;
        enable = 1'b1;
        clear_stats();
        push_desc(64'h7135, 8'd3, 8'd0);
        check("t1_level", 64'(fifo_level), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_datain_early", bs_datain, 64'h7135);
        check("t1_start_low", 64'(bs_start), 64'd0);
        tick();
        check("t1_start_high", 64'(bs_start), 64'd1);
        wait_idle("t1_idle", 200);
        check("t1_starts", 64'(n_start), 64'd1);
        check("t1_dones", 64'(n_fd), 64'd1);

        // Repeat count
        gap_cycles = 16'd4;
        clear_stats();
        push_desc(64'hA5A5_0001_DEAD_BEEF, 8'd7, 8'd2);
        wait_idle("t2_idle", 300);
        check("t2_starts", 64'(n_start), 64'd3);
        check("t2_dones", 64'(n_fd), 64'd3);
        check("t2_space1", 64'(start_q[1] - fd_q[0]), 64'd5);
        check("t2_space2", 64'(start_q[2] - fd_q[1]), 64'd5);
        check("t2_level", 64'(fifo_level), 64'd0);

        // Back-pressure then drain in order
        enable = 1'b0;
        gap_cycles = 16'd0;
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            push_desc(64'h1000 + 64'(i), 8'(i + 1), 8'd0);
            if (i == 3) begin
                check("t3_ready_full", 64'(desc_ready), 64'd0);
                check("t3_level_full", 64'(fifo_level), 64'd4);
            end
        end
        check("t3_level_after5", 64'(fifo_level), 64'd4);
        check("t3_no_start", 64'(n_start), 64'd0);
        check("t3_busy_queued", 64'(busy), 64'd1);
        enable = 1'b1;
        wait_idle("t3_idle", 400);
        check("t3_starts", 64'(n_start), 64'd4);
        for (int i = 0; i < 3; i++) check("t3_space", 64'(start_q[i + 1] - fd_q[i]), 64'd2);

        // Start timeout and recovery
        timeout_cycles = 16'd10;
        stub_hold = 1'b1;
        clear_stats();
        push_desc(64'hDEAD_0001, 8'd9, 8'd0);
        push_desc(64'h0B0B, 8'd10, 8'd0);
        k = 0;
        while (!bs_start && k < 20) begin
            tick();
            k++;
        end
        check("t4_start_seen", 64'(bs_start), 64'd1);
        repeat (10) tick();
        check("t4_not_yet", 64'(bs_rst), 64'd0);
        tick();
        check("t4_bs_rst", 64'(bs_rst), 64'd1);
        check("t4_err", 64'(err_timeout), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_level", 64'(fifo_level), 64'd1);
        tick();
        check("t4_err_sticky", 64'(err_timeout), 64'd1);
        stub_hold = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_clr_rst", 64'(bs_rst), 64'd0);
        check("t4_clr_err", 64'(err_timeout), 64'd0);
        timeout_cycles = 16'd50;
        wait_idle("t4_idle", 200);
        check("t4_starts", 64'(n_start), 64'd2);

        // Asynchronous reset mid-frame
        clear_stats();
        push_desc(64'hC0C0, 8'd1, 8'd0);
        push_desc(64'hD0D0, 8'd2, 8'd0);
        k = 0;
        while (!bs_sysrun && k < 30) begin
            tick();
            k++;
        end
        check("t5_sysrun", 64'(bs_sysrun), 64'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_bs_rst", 64'(bs_rst), 64'd1);
        check("t5_start", 64'(bs_start), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_level", 64'(fifo_level), 64'd0);
        check("t5_ready", 64'(desc_ready), 64'd1);
        check("t5_datain", bs_datain, 64'd0);
        check("t5_phase", 64'(bs_phase_delay), 64'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        #2 check("t5_hold_bs_rst", 64'(bs_rst), 64'd1);
        tick();
        check("t5_release_bs_rst", 64'(bs_rst), 64'd0);
        check("t5_idle_after", 64'(busy), 64'd0);

        // Enable drop during repeats
        gap_cycles = 16'd2;
        clear_stats();
        push_desc(64'h0E0E, 8'd5, 8'd3);
        push_desc(64'h0F0F, 8'd6, 8'd0);
        push_desc(64'h0606, 8'd7, 8'd0);
        enable = 1'b0;
        k = 0;
        while (n_fd < 4 && k < 300) begin
            tick();
            k++;
        end
        check("t6_dones", 64'(n_fd), 64'd4);
        repeat (20) tick();
        check("t6_starts_held", 64'(n_start), 64'd4);
        check("t6_level", 64'(fifo_level), 64'd2);
        check("t6_busy", 64'(busy), 64'd1);
        enable = 1'b1;
        wait_idle("t6_idle", 300);
        check("t6_starts", 64'(n_start), 64'd6);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
